// File: rtl/load_aligner.sv
// Load aligner: tracks outstanding dmem loads and aligns/extends the returned read word.
// Optional sticky protocol-error flag enabled by defining LOAD_ALIGN_ERR_CHECK_EN.
module load_aligner #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_lanes,
    input  logic        req_unsigned,
    input  logic [4:0]  req_rd,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rdata,
    output logic        ld_valid,
    input  logic        ld_ready,
    output logic [4:0]  ld_rd,
    output logic [31:0] ld_data,
    output logic        err
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    // Entry layout: {lanes[3:0], unsigned, rd[4:0]}
    logic [9:0]    fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ld_valid_q, ld_valid_d;
    logic [4:0]    ld_rd_q, ld_rd_d;
    logic [31:0]   ld_data_q, ld_data_d;

    logic          push;
    logic          pop;
    logic [9:0]    head;
    logic [3:0]    head_lanes;
    logic          head_sx;
    logic [31:0]   aligned;

    assign req_ready  = (count_q != FULL);
    assign rsp_ready  = (count_q != '0) && (!ld_valid_q || ld_ready);
    assign push       = req_valid && req_ready;
    assign pop        = rsp_valid && rsp_ready;
    assign head       = fifo_q[rd_ptr_q];
    assign head_lanes = head[9:6];
    assign head_sx    = ~head[5];

    always_comb begin
        case (head_lanes)
            4'b0001: aligned = {{24{head_sx & rdata[7]}},  rdata[7:0]};
            4'b0010: aligned = {{24{head_sx & rdata[15]}}, rdata[15:8]};
            4'b0100: aligned = {{24{head_sx & rdata[23]}}, rdata[23:16]};
            4'b1000: aligned = {{24{head_sx & rdata[31]}}, rdata[31:24]};
            4'b0011: aligned = {{16{head_sx & rdata[15]}}, rdata[15:0]};
            4'b1100: aligned = {{16{head_sx & rdata[31]}}, rdata[31:16]};
            default: aligned = rdata;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ld_valid_d = ld_valid_q;
        ld_rd_d    = ld_rd_q;
        ld_data_d  = ld_data_q;
        // A same-cycle accept reloads the register even while the old result drains
        if (pop) begin
            ld_valid_d = 1'b1;
            ld_rd_d    = head[4:0];
            ld_data_d  = aligned;
        end else if (ld_ready) begin
            ld_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ld_valid_q <= 1'b0;
            ld_rd_q    <= '0;
            ld_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ld_rd_d;
            ld_data_q  <= ld_data_d;
            if (push) fifo_q[wr_ptr_q] <= {req_lanes, req_unsigned, req_rd};
        end
    end

    assign ld_valid = ld_valid_q;
    assign ld_rd    = ld_rd_q;
    assign ld_data  = ld_data_q;

`ifdef LOAD_ALIGN_ERR_CHECK_EN
    logic err_q, err_d;
    logic lanes_legal;

    always_comb begin
        case (req_lanes)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: lanes_legal = 1'b1;
            default:                   lanes_legal = 1'b0;
        endcase
        err_d = err_q | (rsp_valid && (count_q == '0)) | (push && !lanes_legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_load_aligner.sv
// Randomized and directed bench for load_aligner against a queue-based reference model.
module tb_load_aligner;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_lanes;
    logic        req_unsigned;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        err;

    load_aligner #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_lanes(req_lanes),
        .req_unsigned(req_unsigned), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rdata(rdata),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd),
        .ld_data(ld_data), .err(err)
    );

    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [9:0]  q[$];
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_err;
    logic [3:0]  legal [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference alignment: lowest set lane gives the byte offset, lane count gives the size.
    function automatic logic [31:0] align(input logic [3:0] ln, input logic un, input logic [31:0] w);
        int unsigned nb;
        int unsigned off;
        logic [31:0] v;
        logic [31:0] mask;
        if (!(ln inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC})) return w;
        nb  = $countones(ln);
        off = 0;
        while (!ln[off]) off++;
        mask = (nb == 1) ? 32'hFF : 32'hFFFF;
        v = (w >> (8 * off)) & mask;
        if (!un && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_valid = 1'b0;
        m_rd    = '0;
        m_data  = '0;
        m_err   = 1'b0;
    endtask

    task automatic check_outputs();
        chk("ld_valid", 32'(ld_valid), 32'(m_valid));
        chk("ld_rd",    32'(ld_rd),    32'(m_rd));
        chk("ld_data",  ld_data,       m_data);
        chk("err",      32'(err),      32'(m_err));
    endtask

    // Called at posedge+1: drive, check handshakes, clock, update model, check registers.
    task automatic cycle(input logic rv, input logic [3:0] ln, input logic un, input logic [4:0] rd,
                         input logic sv, input logic [31:0] rdat, input logic lr);
        logic       exp_rq;
        logic       exp_rs;
        logic [9:0] e;
        req_valid = rv; req_lanes = ln; req_unsigned = un; req_rd = rd;
        rsp_valid = sv; rdata = rdat; ld_ready = lr;
        #1;
        exp_rq = (q.size() != DEPTH);
        exp_rs = (q.size() != 0) && (!m_valid || lr);
        chk("req_ready", 32'(req_ready), 32'(exp_rq));
        chk("rsp_ready", 32'(rsp_ready), 32'(exp_rs));
        @(posedge clk);
`ifdef LOAD_ALIGN_ERR_CHECK_EN
        if (sv && q.size() == 0) m_err = 1'b1;
        if (rv && exp_rq && !(ln inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF})) m_err = 1'b1;
`endif
        if (sv && exp_rs) begin
            e       = q.pop_front();
            m_valid = 1'b1;
            m_rd    = e[4:0];
            m_data  = align(e[9:6], e[5], rdat);
        end else if (lr) begin
            m_valid = 1'b0;
        end
        if (rv && exp_rq) q.push_back({ln, un, rd});
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic lr);
        cycle(1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h0, lr);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; rsp_valid = 1'b0; ld_ready = 1'b0;
        #1;
        model_clear();
        check_outputs();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_ready", 32'(rsp_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ln;
        rst_n = 1'b0;
        req_valid = 1'b0; req_lanes = '0; req_unsigned = 1'b0; req_rd = '0;
        rsp_valid = 1'b0; rdata = '0; ld_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Signed byte from lane 1
        cycle(1'b1, 4'b0010, 1'b0, 5'd5, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0, 1'b1, 32'h1234_80FF, 1'b1);
        chk("byte_valid", 32'(ld_valid), 32'd1);
        chk("byte_rd",    32'(ld_rd),    32'd5);
        chk("byte_data",  ld_data,       32'hFFFF_FF80);

        // Upper half, unsigned then signed
        cycle(1'b1, 4'b1100, 1'b1, 5'd7, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0, 1'b1, 32'h8001_0000, 1'b1);
        chk("half_u_data", ld_data, 32'h0000_8001);
        cycle(1'b1, 4'b1100, 1'b0, 5'd7, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0, 1'b1, 32'h8001_0000, 1'b1);
        chk("half_s_data", ld_data, 32'hFFFF_8001);

        // Fill to DEPTH, third push refused, responses in issue order
        cycle(1'b1, 4'b1111, 1'b0, 5'd1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 4'b1111, 1'b0, 5'd2, 1'b0, 32'h0, 1'b1);
        chk("full_ready", 32'(req_ready), 32'd0);
        cycle(1'b1, 4'b1111, 1'b0, 5'd3, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0, 1'b1, 32'hA5A5_0001, 1'b1);
        chk("order_rd1", 32'(ld_rd), 32'd1);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0, 1'b1, 32'hA5A5_0002, 1'b1);
        chk("order_rd2", 32'(ld_rd), 32'd2);
        chk("empty_rsp_ready", 32'(rsp_ready), 32'd0);
        idle(1'b1);

        // Backpressure hold, then release
        cycle(1'b1, 4'b0001, 1'b1, 5'd9,  1'b0, 32'h0, 1'b0);
        cycle(1'b1, 4'b0100, 1'b0, 5'd10, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0,  1'b1, 32'h0000_00C3, 1'b0);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0,  1'b1, 32'h00F0_0000, 1'b0);
        chk("hold_rd",   32'(ld_rd), 32'd9);
        chk("hold_data", ld_data,    32'h0000_00C3);
        cycle(1'b0, 4'b0000, 1'b0, 5'd0,  1'b1, 32'h00F0_0000, 1'b1);
        chk("release_rd",   32'(ld_rd), 32'd10);
        chk("release_data", ld_data,    32'hFFFF_FFF0);
        idle(1'b1);

        // Simultaneous push and pop at count 1, pointers wrap
        cycle(1'b1, 4'b0011, 1'b0, 5'd20, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'b0011, 1'b0, 5'(21 + i), 1'b1, $urandom, 1'b1);
            chk("pp_rd", 32'(ld_rd), 32'(20 + i));
        end
        cycle(1'b0, 4'b0000, 1'b0, 5'd0, 1'b1, 32'h0000_7FFF, 1'b1);
        chk("pp_last_rd",   32'(ld_rd), 32'd24);
        chk("pp_last_data", ld_data,    32'h0000_7FFF);

        // Response on empty FIFO is ignored
        cycle(1'b0, 4'b0000, 1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b1);

        // Reset in the middle of traffic
        cycle(1'b1, 4'b1000, 1'b0, 5'd11, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 4'b1000, 1'b0, 5'd12, 1'b1, 32'h8000_0000, 1'b0);
        do_reset();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) ln = 4'($urandom);
            else                           ln = legal[$urandom_range(0, 6)];
            cycle(1'($urandom), ln, 1'($urandom), 5'($urandom), 1'($urandom),
                  $urandom, ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
